// File: rtl/sine_pkg.sv
// Shared sine generator/analyser definitions.
package sine_pkg;

    localparam int SINE_SIZE = 8;
    localparam logic [SINE_SIZE-1:0] MIDPOINT = 8'd128;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        TRACK
    } ana_state_e;

endpackage

// File: rtl/sine_crossing_detect.sv
// Rising mid-level crossing detector with hysteresis re-arm.
module sine_crossing_detect
    import sine_pkg::*;
#(
    parameter int HYST = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [SINE_SIZE-1:0] sample,
    input  logic                 clear,
    output logic                 crossing
);

    localparam logic [SINE_SIZE-1:0] ARM_LEVEL =
        SINE_SIZE'(int'(MIDPOINT) - HYST);

    logic armed_q;
    logic armed_d;

    assign crossing = armed_q && (sample >= MIDPOINT);

    always_comb begin
        armed_d = armed_q;
        if (sample_valid) begin
            if (crossing || clear) begin
                armed_d = 1'b0;
            end else if (sample <= ARM_LEVEL) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/sine_period_analyser.sv
// Measures period, peak and trough of the sine sample stream; flags lock.
module sine_period_analyser
    import sine_pkg::*;
#(
    parameter int HYST       = 4,
    parameter int CNT_W      = 16,
    parameter int MAX_PERIOD = 1023,
    parameter int PERIOD_TOL = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [SINE_SIZE-1:0] sample,
    output logic [CNT_W-1:0]     period,
    output logic [SINE_SIZE-1:0] peak,
    output logic [SINE_SIZE-1:0] trough,
    output logic                 meas_valid,
    output logic                 locked
);

    ana_state_e state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     prev_period_q, prev_period_d;
    logic [SINE_SIZE-1:0] run_max_q, run_max_d;
    logic [SINE_SIZE-1:0] run_min_q, run_min_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic [SINE_SIZE-1:0] peak_q, peak_d;
    logic [SINE_SIZE-1:0] trough_q, trough_d;
    logic                 meas_valid_q, meas_valid_d;
    logic                 locked_q, locked_d;

    logic                 crossing;
    logic                 timeout;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]       abs_diff;
    logic                 in_tol;

    sine_crossing_detect #(
        .HYST(HYST)
    ) u_detect (
        .clock       (clock),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample      (sample),
        .clear       (timeout),
        .crossing    (crossing)
    );

    assign timeout = sample_valid && !crossing && (state_q != SEARCH)
                   && (cnt_q == CNT_W'(MAX_PERIOD));

    assign diff     = $signed({1'b0, cnt_q}) - $signed({1'b0, prev_period_q});
    assign abs_diff = (diff < 0) ? $unsigned(-diff) : $unsigned(diff);
    assign in_tol   = (abs_diff <= (CNT_W + 1)'(PERIOD_TOL))
                   && (prev_period_q != '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prev_period_d = prev_period_q;
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        period_d      = period_q;
        peak_d        = peak_q;
        trough_d      = trough_q;
        meas_valid_d  = 1'b0;
        locked_d      = locked_q;
        if (sample_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (crossing) begin
                        state_d   = MEASURE;
                        cnt_d     = CNT_W'(1);
                        run_max_d = sample;
                        run_min_d = sample;
                    end
                end
                MEASURE, TRACK: begin
                    if (crossing) begin
                        period_d      = cnt_q;
                        peak_d        = run_max_q;
                        trough_d      = run_min_q;
                        meas_valid_d  = 1'b1;
                        locked_d      = (state_q == TRACK) && in_tol;
                        prev_period_d = cnt_q;
                        cnt_d         = CNT_W'(1);
                        run_max_d     = sample;
                        run_min_d     = sample;
                        state_d       = TRACK;
                    end else if (timeout) begin
                        state_d       = SEARCH;
                        locked_d      = 1'b0;
                        prev_period_d = '0;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (sample > run_max_q) run_max_d = sample;
                        if (sample < run_min_q) run_min_d = sample;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= SEARCH;
            cnt_q         <= '0;
            prev_period_q <= '0;
            run_max_q     <= '0;
            run_min_q     <= '1;
            period_q      <= '0;
            peak_q        <= '0;
            trough_q      <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_period_q <= prev_period_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            period_q      <= period_d;
            peak_q        <= peak_d;
            trough_q      <= trough_d;
            meas_valid_q  <= meas_valid_d;
            locked_q      <= locked_d;
        end
    end

    assign period     = period_q;
    assign peak       = peak_q;
    assign trough     = trough_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;

endmodule
